// File: rtl/trap_seq.sv
// trap_seq: machine-mode trap sequencer. Takes one ecall/ebreak/mret request
// at a time. Sends the required CSR updates, one per cycle, through the single
// CSR write port. Then pulses a PC redirect to fetch. Holds busy_o for the
// whole sequence.
//
// Configuration macro: TRAP_SEQ_MTVAL_EN
//   defined   - ecall/ebreak also write mtval with the trapping instruction
//   undefined - mtval step is skipped and inst_data_i is unused
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   trap_valid_i      request valid (accepted when trap_ready_o is high)
//   trap_ready_o      high only while idle
//   trap_type_i       00 ecall, 01 ebreak, 10 mret, 11 reserved
//   pc_i, inst_data_i PC and encoding of the trapping instruction
//   csr_raddr_o       CSR read address (csr_rdata_i returns in the same cycle)
//   csr_rdata_i       CSR read data
//   csr_wen_o/_waddr_o/_wdata_o   CSR write port
//   redirect_valid_o  one-cycle redirect pulse
//   redirect_pc_o     redirect target
//   busy_o            pipeline stall while a sequence is in flight
module trap_seq #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trap_valid_i,
    output logic                trap_ready_o,
    input  logic [1:0]          trap_type_i,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [INST_LEN-1:0] inst_data_i,
    output logic [11:0]         csr_raddr_o,
    input  logic [XLEN-1:0]     csr_rdata_i,
    output logic                csr_wen_o,
    output logic [11:0]         csr_waddr_o,
    output logic [XLEN-1:0]     csr_wdata_o,
    output logic                redirect_valid_o,
    output logic [XLEN-1:0]     redirect_pc_o,
    output logic                busy_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
`ifdef TRAP_SEQ_MTVAL_EN
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
`endif

    localparam logic [1:0] TT_ECALL  = 2'b00;
    localparam logic [1:0] TT_EBREAK = 2'b01;
    localparam logic [1:0] TT_MRET   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MTVAL,
        S_W_MSTAT,
        S_RET_MSTAT,
        S_REDIR,
        S_RSVD      // single busy cycle for the reserved trap type
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic [XLEN-1:0]     pc_q;
    logic [1:0]          type_q;
`ifdef TRAP_SEQ_MTVAL_EN
    logic [INST_LEN-1:0] inst_q;
`else
    logic                unused_inst;
    assign unused_inst = ^inst_data_i;
`endif

    assign accept = trap_valid_i && (state == S_IDLE);

    // State register and request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc_q   <= '0;
            type_q <= '0;
`ifdef TRAP_SEQ_MTVAL_EN
            inst_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                pc_q   <= pc_i;
                type_q <= trap_type_i;
`ifdef TRAP_SEQ_MTVAL_EN
                inst_q <= inst_data_i;
`endif
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (trap_valid_i) begin
                    case (trap_type_i)
                        TT_ECALL, TT_EBREAK: state_nxt = S_W_MEPC;
                        TT_MRET:             state_nxt = S_RET_MSTAT;
                        default:             state_nxt = S_RSVD;
                    endcase
                end
            end
`ifdef TRAP_SEQ_MTVAL_EN
            S_W_MCAUSE:  state_nxt = S_W_MTVAL;
            S_W_MTVAL:   state_nxt = S_W_MSTAT;
`else
            S_W_MCAUSE:  state_nxt = S_W_MSTAT;
`endif
            S_W_MEPC:    state_nxt = S_W_MCAUSE;
            S_W_MSTAT:   state_nxt = S_REDIR;
            S_RET_MSTAT: state_nxt = S_REDIR;
            S_REDIR:     state_nxt = S_IDLE;
            S_RSVD:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output decode. Only csr_rdata_i passes through combinationally.
    always_comb begin
        trap_ready_o     = (state == S_IDLE);
        busy_o           = (state != S_IDLE);
        csr_raddr_o      = '0;
        csr_wen_o        = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        case (state)
            S_W_MEPC: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = pc_q;
            end
            S_W_MCAUSE: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = (type_q == TT_EBREAK) ? XLEN'(3) : XLEN'(11);
            end
`ifdef TRAP_SEQ_MTVAL_EN
            S_W_MTVAL: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = XLEN'(inst_q);
            end
`endif
            S_W_MSTAT: begin
                // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
                csr_raddr_o        = CSR_MSTATUS;
                csr_wen_o          = 1'b1;
                csr_waddr_o        = CSR_MSTATUS;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[7]     = csr_rdata_i[3];
                csr_wdata_o[3]     = 1'b0;
                csr_wdata_o[12:11] = 2'b11;
            end
            S_RET_MSTAT: begin
                // Trap return: MIE <- MPIE, MPIE <- 1, MPP stays M (M-only core)
                csr_raddr_o        = CSR_MSTATUS;
                csr_wen_o          = 1'b1;
                csr_waddr_o        = CSR_MSTATUS;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[3]     = csr_rdata_i[7];
                csr_wdata_o[7]     = 1'b1;
                csr_wdata_o[12:11] = 2'b11;
            end
            S_REDIR: begin
                // Direct vectoring only: low two bits (mtvec MODE) are dropped
                csr_raddr_o      = (type_q == TT_MRET) ? CSR_MEPC : CSR_MTVEC;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = {csr_rdata_i[XLEN-1:2], 2'b00};
            end
            default: ;
        endcase
    end

endmodule
